// File: rtl/pipe_pkg.sv
// Shared state encoding and constants for the pipeline sequencing controller.
// Opcode values are shared with the decode stage.
package pipe_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_LU_STALL = 3'd2,
        S_FLUSH    = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int CNT_W_DEF        = 16;
    localparam int FCNT_W           = 3;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use comparator: a LOAD in execute whose rd feeds a live source
// operand of the instruction sitting in the decode output register.
module hazard_detect (
    input  logic [4:0] id_rs1_i,
    input  logic       id_rs1en_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs2en_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_rden_i,
    input  logic       ex_load_i,
    output logic       lu_hazard_o
);

    logic rs1_hit;
    logic rs2_hit;
    logic rd_live;

    assign rs1_hit = id_rs1en_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_rs2en_i && (id_rs2_i == ex_rd_i);
    // x0 never carries a value, so it can never create a dependency
    assign rd_live = ex_load_i && ex_rden_i && (ex_rd_i != 5'd0);

    assign lu_hazard_o = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: run/hold/bubble/flush control for
// IF, ID and EX, plus a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       id_rs1,
    input  logic             id_rs1en,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2en,
    input  logic             id_system,
    input  logic [4:0]       ex_rd,
    input  logic             ex_rden,
    input  logic             ex_load,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             run_en,
    output logic             front_hold,
    output logic             id_bubble,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [FCNT_W-1:0] FC_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FC_ONE    = FCNT_W'(1);

    state_t            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  scnt_q, scnt_d;

    logic lu_hazard;
    logic mem_stall;
    logic stall_cycle;

    hazard_detect u_hazard (
        .id_rs1_i    (id_rs1),
        .id_rs1en_i  (id_rs1en),
        .id_rs2_i    (id_rs2),
        .id_rs2en_i  (id_rs2en),
        .ex_rd_i     (ex_rd),
        .ex_rden_i   (ex_rden),
        .ex_load_i   (ex_load),
        .lu_hazard_o (lu_hazard)
    );

    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) state_d = S_RUN;
            end
            S_RUN, S_LU_STALL: begin
                // A bubble lasts one cycle, so the hazard is masked there
                if (mem_stall) begin
                    state_d = S_MEM_WAIT;
                    pend_d  = 1'b0;
                end else if (ex_redirect) begin
                    state_d = S_FLUSH;
                    fcnt_d  = FC_RELOAD;
                end else if (lu_hazard && (state_q == S_RUN)) begin
                    state_d = S_LU_STALL;
                end else if (id_system) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (mem_stall) begin
                    // This flush cycle has been spent; park what remains
                    state_d = S_MEM_WAIT;
                    pend_d  = (fcnt_q != '0);
                    if (fcnt_q != '0) fcnt_d = fcnt_q - FC_ONE;
                end else if (ex_redirect) begin
                    fcnt_d = FC_RELOAD;
                end else if (fcnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    fcnt_d = fcnt_q - FC_ONE;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = pend_q ? S_FLUSH : S_RUN;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        run_en     = 1'b0;
        front_hold = 1'b0;
        id_bubble  = 1'b0;
        flush      = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            S_RUN: begin
                run_en = 1'b1;
            end
            S_LU_STALL: begin
                run_en     = 1'b1;
                front_hold = 1'b1;
                id_bubble  = 1'b1;
            end
            S_FLUSH: begin
                run_en = 1'b1;
                flush  = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                run_en = 1'b0;
            end
        endcase
    end

    assign stall_cycle = (!run_en || front_hold) &&
                         (state_q != S_IDLE) &&
                         (state_q != S_HALT);

    always_comb begin
        scnt_d = scnt_q;
        if (stall_cycle && !(&scnt_q)) scnt_d = scnt_q + 1'b1;
    end

    assign stall_cnt = scnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            pend_q  <= 1'b0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
            scnt_q  <= scnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_pipe_ctrl;

    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic [4:0]    id_rs1;
    logic          id_rs1en;
    logic [4:0]    id_rs2;
    logic          id_rs2en;
    logic          id_system;
    logic [4:0]    ex_rd;
    logic          ex_rden;
    logic          ex_load;
    logic          ex_redirect;
    logic          mem_req;
    logic          mem_ready;
    logic          run_en;
    logic          front_hold;
    logic          id_bubble;
    logic          flush;
    logic          halted;
    logic [CW-1:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .id_rs1      (id_rs1),
        .id_rs1en    (id_rs1en),
        .id_rs2      (id_rs2),
        .id_rs2en    (id_rs2en),
        .id_system   (id_system),
        .ex_rd       (ex_rd),
        .ex_rden     (ex_rden),
        .ex_load     (ex_load),
        .ex_redirect (ex_redirect),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .run_en      (run_en),
        .front_hold  (front_hold),
        .id_bubble   (id_bubble),
        .flush       (flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the pipeline is doing this cycle
    typedef enum {M_IDLE, M_RUN, M_BUB, M_FLUSH, M_WAIT, M_HALT} mode_t;
    mode_t m_mode;
    int    m_left;
    int    m_owed;
    int    m_stalls;

    function automatic bit lu_now();
        bit dep;
        dep = (id_rs1en && id_rs1 == ex_rd) || (id_rs2en && id_rs2 == ex_rd);
        return ex_load && ex_rden && (ex_rd != 0) && dep;
    endfunction

    // Inputs change at negedge+1, so at negedge they still hold the
    // values the DUT sampled on the preceding rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            m_mode   = M_IDLE;
            m_left   = 0;
            m_owed   = 0;
            m_stalls = 0;
        end else begin
            if ((m_mode == M_WAIT || m_mode == M_BUB) && m_stalls < CMAX)
                m_stalls++;
            case (m_mode)
                M_IDLE, M_HALT: if (start) m_mode = M_RUN;
                M_RUN, M_BUB: begin
                    if (mem_req && !mem_ready) begin
                        m_mode = M_WAIT;
                        m_owed = 0;
                    end else if (ex_redirect) begin
                        m_mode = M_FLUSH;
                        m_left = FC;
                    end else if (m_mode == M_RUN && lu_now()) begin
                        m_mode = M_BUB;
                    end else if (id_system) begin
                        m_mode = M_HALT;
                    end else begin
                        m_mode = M_RUN;
                    end
                end
                M_FLUSH: begin
                    m_left--;
                    if (mem_req && !mem_ready) begin
                        m_owed = m_left;
                        m_mode = M_WAIT;
                    end else if (ex_redirect) begin
                        m_left = FC;
                    end else if (m_left == 0) begin
                        m_mode = M_RUN;
                    end
                end
                M_WAIT: begin
                    if (mem_ready) begin
                        if (m_owed > 0) begin
                            m_mode = M_FLUSH;
                            m_left = m_owed;
                        end else begin
                            m_mode = M_RUN;
                        end
                    end
                end
                default: m_mode = M_IDLE;
            endcase
            chk("m_run_en", int'(run_en),
                int'(m_mode == M_RUN || m_mode == M_BUB || m_mode == M_FLUSH));
            chk("m_front_hold", int'(front_hold), int'(m_mode == M_BUB));
            chk("m_id_bubble", int'(id_bubble), int'(m_mode == M_BUB));
            chk("m_flush", int'(flush), int'(m_mode == M_FLUSH));
            chk("m_halted", int'(halted), int'(m_mode == M_HALT));
            chk("m_stall_cnt", int'(stall_cnt), m_stalls);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_in();
        start       = 1'b0;
        id_rs1      = 5'd0;
        id_rs1en    = 1'b0;
        id_rs2      = 5'd0;
        id_rs2en    = 1'b0;
        id_system   = 1'b0;
        ex_rd       = 5'd0;
        ex_rden     = 1'b0;
        ex_load     = 1'b0;
        ex_redirect = 1'b0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_load  = 1'b1;
        ex_rd    = rd;
        ex_rden  = 1'b1;
        id_rs2en = 1'b1;
        id_rs2   = 5'd5;
    endtask

    task automatic rand_in();
        start       = ($urandom_range(99) < 8);
        id_rs1      = 5'($urandom_range(3));
        id_rs1en    = ($urandom_range(99) < 60);
        id_rs2      = 5'($urandom_range(3));
        id_rs2en    = ($urandom_range(99) < 60);
        id_system   = ($urandom_range(99) < 3);
        ex_rd       = 5'($urandom_range(3));
        ex_rden     = ($urandom_range(99) < 80);
        ex_load     = ($urandom_range(99) < 35);
        ex_redirect = ($urandom_range(99) < 10);
        mem_req     = ($urandom_range(99) < 15);
        mem_ready   = ($urandom_range(99) < 40);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        clear_in();
        reset = 1'b0;
        step();
        step();
        chk("rst_run_en", int'(run_en), 0);
        chk("rst_front_hold", int'(front_hold), 0);
        chk("rst_id_bubble", int'(id_bubble), 0);
        chk("rst_flush", int'(flush), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        reset = 1'b1;
        step();
        chk("idle_run_en", int'(run_en), 0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_run_en", int'(run_en), 1);
        chk("start_flush", int'(flush), 0);
        chk("start_stall", int'(stall_cnt), 0);

        // load-use on rs2 with rd=5: one bubble cycle
        set_lu(5'd5);
        step();
        clear_in();
        chk("lu_front_hold", int'(front_hold), 1);
        chk("lu_id_bubble", int'(id_bubble), 1);
        chk("lu_run_en", int'(run_en), 1);
        step();
        chk("lu_end_hold", int'(front_hold), 0);
        chk("lu_end_bubble", int'(id_bubble), 0);
        chk("lu_stall_cnt", int'(stall_cnt), 1);

        // rd=0 never stalls
        set_lu(5'd0);
        id_rs2 = 5'd0;
        step();
        clear_in();
        chk("lu_x0_hold", int'(front_hold), 0);

        // single redirect: two flush cycles
        ex_redirect = 1'b1;
        step();
        ex_redirect = 1'b0;
        chk("rd1_flush_c1", int'(flush), 1);
        step();
        chk("rd1_flush_c2", int'(flush), 1);
        step();
        chk("rd1_flush_end", int'(flush), 0);

        // second redirect during first flush cycle: three flush cycles
        ex_redirect = 1'b1;
        step();
        chk("rd2_flush_c1", int'(flush), 1);
        step();
        ex_redirect = 1'b0;
        chk("rd2_flush_c2", int'(flush), 1);
        step();
        chk("rd2_flush_c3", int'(flush), 1);
        step();
        chk("rd2_flush_end", int'(flush), 0);

        // asynchronous reset while flushing
        ex_redirect = 1'b1;
        step();
        ex_redirect = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_flush", int'(flush), 0);
        chk("async_rst_run_en", int'(run_en), 0);
        chk("async_rst_cnt", int'(stall_cnt), 0);
        step();
        reset = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;

        // memory wait of four cycles
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mw_run_en", int'(run_en), 0);
            if (i == 3) mem_ready = 1'b1;
        end
        step();
        clear_in();
        chk("mw_end_run_en", int'(run_en), 1);
        chk("mw_stall_cnt", int'(stall_cnt), 4);

        // redirect beats load-use, then a mem wait interrupts the flush
        ex_redirect = 1'b1;
        set_lu(5'd5);
        step();
        clear_in();
        chk("rl_flush", int'(flush), 1);
        chk("rl_no_bubble", int'(id_bubble), 0);
        mem_req = 1'b1;
        step();
        chk("rlm_wait_run_en", int'(run_en), 0);
        chk("rlm_wait_flush", int'(flush), 0);
        mem_ready = 1'b1;
        step();
        clear_in();
        chk("rlm_resume_flush", int'(flush), 1);
        step();
        chk("rlm_resume_end", int'(flush), 0);
        chk("rlm_stall_cnt", int'(stall_cnt), 5);

        // SYSTEM halts; stall count frozen; hazards ignored
        id_system = 1'b1;
        step();
        clear_in();
        chk("halt_halted", int'(halted), 1);
        chk("halt_run_en", int'(run_en), 0);
        mem_req     = 1'b1;
        ex_redirect = 1'b1;
        set_lu(5'd5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_stay", int'(halted), 1);
            chk("halt_cnt_frozen", int'(stall_cnt), 5);
        end
        clear_in();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("halt_exit_run", int'(run_en), 1);
        chk("halt_exit_halted", int'(halted), 0);

        // saturation at all-ones
        mem_req = 1'b1;
        for (int i = 0; i < 14; i++) step();
        chk("sat_cnt", int'(stall_cnt), CMAX);
        mem_ready = 1'b1;
        step();
        clear_in();
        step();
        chk("sat_hold", int'(stall_cnt), CMAX);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            if (i % 400 == 399) begin
                clear_in();
                do_reset();
            end else begin
                step();
            end
        end
        clear_in();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
